// File: rtl/fft_pkg.sv
// Shared complex-arithmetic types, widths and saturation helpers for the FFT datapath.
package fft_pkg;
    localparam int DW = 16;          // bits per real/imag component (Q1.15)
    localparam int SW = DW + 1;      // sum/diff width
    localparam int PW = 2*DW + 3;    // full conj-product width
    localparam int BW = PW - DW;     // product width after the >>> DW scale

    localparam logic signed [PW-1:0] RND  = PW'(1) << (DW-1);
    localparam logic signed [BW-1:0] BMAX = BW'((1 << (DW-1)) - 1);
    localparam logic signed [BW-1:0] BMIN = BW'(-(1 << (DW-1)));

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
    } cplx_w_t;

    function automatic logic sat_clip(input logic signed [BW-1:0] x);
        return (x > BMAX) || (x < BMIN);
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [BW-1:0] x);
        if (x > BMAX) return {1'b0, {(DW-1){1'b1}}};
        if (x < BMIN) return {1'b1, {(DW-1){1'b0}}};
        return x[DW-1:0];
    endfunction
endpackage

// File: rtl/cplx_mult_conj.sv
// Registered multiply of a (DW+1)-bit complex operand by the conjugate of a Q1.15 twiddle.
import fft_pkg::*;

module cplx_mult_conj (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [SW-1:0] dr,
    input  logic signed [SW-1:0] di,
    input  cplx_t                w,
    output logic signed [PW-1:0] pr,
    output logic signed [PW-1:0] pi
);
    logic signed [PW-1:0] dre, die, wre, wie;

    // Sign-extend everything to the full product width so no bits are lost.
    assign dre = {{(PW-SW){dr[SW-1]}}, dr};
    assign die = {{(PW-SW){di[SW-1]}}, di};
    assign wre = {{(PW-DW){w.re[DW-1]}}, w.re};
    assign wie = {{(PW-DW){w.im[DW-1]}}, w.im};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr <= '0;
            pi <= '0;
        end else if (en) begin
            pr <= dre*wre + die*wie;
            pi <= die*wre - dre*wie;
        end
    end
endmodule

// File: rtl/inv_butterfly_pipe.sv
// Three-stage inverse radix-2 butterfly: A = (X0+X1)/2, B = conj(W)*(X0-X1)/2,
// with a single global stall driven by the output handshake.
import fft_pkg::*;

module inv_butterfly_pipe (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] X0,
    input  logic [2*DW-1:0] X1,
    input  logic [2*DW-1:0] W,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] A_out,
    output logic [2*DW-1:0] B_out,
    output logic            out_sat
);
    logic    en;
    cplx_t   x0, x1;
    logic    s1_valid, s2_valid;
    cplx_w_t s1_sum, s1_diff, s2_sum;
    cplx_t   s1_w;
    logic signed [PW-1:0] s2_pr, s2_pi;

    assign x0       = X0;
    assign x1       = X1;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // S1: widen by one bit so X0+/-X1 never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_w     <= '0;
        end else if (en) begin
            s1_valid   <= in_valid;
            s1_sum.re  <= {x0.re[DW-1], x0.re} + {x1.re[DW-1], x1.re};
            s1_sum.im  <= {x0.im[DW-1], x0.im} + {x1.im[DW-1], x1.im};
            s1_diff.re <= {x0.re[DW-1], x0.re} - {x1.re[DW-1], x1.re};
            s1_diff.im <= {x0.im[DW-1], x0.im} - {x1.im[DW-1], x1.im};
            s1_w       <= W;
        end
    end

    // S2: conj multiply on the B path, sum simply delayed on the A path.
    cplx_mult_conj u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .dr    (s1_diff.re),
        .di    (s1_diff.im),
        .w     (s1_w),
        .pr    (s2_pr),
        .pi    (s2_pi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sum   <= s1_sum;
        end
    end

    // S3: round-half-up halving for A; product >>> DW (Q1.15 >>15 then /2) for B.
    logic signed [PW-1:0] pr_rnd, pi_rnd;
    logic signed [BW-1:0] br, bi;
    logic        [SW-1:0] ar_rnd, ai_rnd;

    assign pr_rnd = s2_pr + RND;
    assign pi_rnd = s2_pi + RND;
    assign br     = pr_rnd[PW-1:DW];
    assign bi     = pi_rnd[PW-1:DW];
    assign ar_rnd = s2_sum.re + SW'(1);
    assign ai_rnd = s2_sum.im + SW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            A_out     <= '0;
            B_out     <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            A_out     <= {ar_rnd[SW-1:1], ai_rnd[SW-1:1]};
            B_out     <= {sat_dw(br), sat_dw(bi)};
            out_sat   <= sat_clip(br) || sat_clip(bi);
        end
    end
endmodule
